item_drawer: RTL and testbench

- Reader side of the item record RAM. Once per frame it walks item records 0..quantity-1 through the shared draw_stone_flag/draw_index read port.
- For each record it erases the item's previously drawn 16x16 footprint when needed, then plots the current footprint into the VGA framebuffer.
- Sits between the item RAM owned by the rope controller and the VGA adapter's pixel-write port. The rope controller stalls its frame steps while draw_stone_flag is high.

---
 rtl/item_pkg.sv | 57 +++++
 rtl/item_shadow.sv | 26 ++
 rtl/item_sprite_rom.sv | 29 ++
 rtl/item_drawer.sv | 217 +++++++++++++++++++++
 tb/tb_item_drawer.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/item_pkg.sv
// Shared definitions for the item drawer: record layout, type codes, colours and scan geometry.
package item_pkg;

    localparam int unsigned X_MSB     = 28;
    localparam int unsigned X_LSB     = 19;
    localparam int unsigned Y_MSB     = 16;
    localparam int unsigned Y_LSB     = 7;
    localparam int unsigned TYPE_MSB  = 3;
    localparam int unsigned TYPE_LSB  = 2;
    localparam int unsigned VISIBLE   = 1;
    localparam int unsigned MOVING    = 0;

    localparam int unsigned COORD_W     = 10;
    localparam int unsigned COL_W       = 9;
    localparam int unsigned IDX_W       = 4;
    localparam int unsigned SPRITE_SIZE = 16;
    localparam int unsigned SPRITE_BITS = $clog2(SPRITE_SIZE);
    localparam int unsigned SCAN_W      = 2 * SPRITE_BITS;
    localparam int unsigned SCREEN_W    = 320;
    localparam int unsigned SCREEN_H    = 240;

    localparam logic [1:0] TYPE_STONE = 2'b00;
    localparam logic [1:0] TYPE_GOLD  = 2'b01;

    localparam logic [COL_W-1:0] COL_BG      = 9'h000;
    localparam logic [COL_W-1:0] COL_STONE   = 9'h16D;
    localparam logic [COL_W-1:0] COL_GOLD    = 9'h1F8;
    localparam logic [COL_W-1:0] COL_DIAMOND = 9'h03F;

    typedef struct packed {
        logic               valid;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } shadow_t;

    localparam int unsigned SHADOW_W = $bits(shadow_t);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_DECODE,
        S_ERASE,
        S_DRAW,
        S_NEXT,
        S_DONE
    } state_t;

    function automatic logic [COL_W-1:0] type_colour(input logic [1:0] t);
        case (t)
            TYPE_STONE: type_colour = COL_STONE;
            TYPE_GOLD:  type_colour = COL_GOLD;
            default:    type_colour = COL_DIAMOND;
        endcase
    endfunction

endpackage

// File: rtl/item_shadow.sv
// Last-drawn position of each item record, {valid, x, y}; one async read port, one write port.
module item_shadow
    import item_pkg::*;
(
    input  logic                clock,
    input  logic                resetn,
    input  logic [IDX_W-1:0]    rd_addr,
    output logic [SHADOW_W-1:0] rd_data,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_addr,
    input  logic [SHADOW_W-1:0] wr_data
);

    logic [SHADOW_W-1:0] mem [16];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/item_sprite_rom.sv
// Per-type sprite bitmap, built only with ITEM_SPRITE_ROM_EN; 9'h000 marks a transparent pixel.
`ifdef ITEM_SPRITE_ROM_EN
module item_sprite_rom
    import item_pkg::*;
(
    input  logic              clock,
    input  logic              resetn,
    input  logic [SCAN_W+1:0] addr,
    output logic [COL_W-1:0]  q
);

    localparam logic [SPRITE_BITS-1:0] EDGE_MAX = SPRITE_BITS'(SPRITE_SIZE - 1);

    logic [SPRITE_BITS-1:0] row;
    logic [SPRITE_BITS-1:0] col;
    logic                   border;

    assign row    = addr[SCAN_W-1:SPRITE_BITS];
    assign col    = addr[SPRITE_BITS-1:0];
    assign border = (row == '0) || (row == EDGE_MAX) || (col == '0) || (col == EDGE_MAX);

    // Outline ring is transparent, the interior takes the solid type colour.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) q <= '0;
        else         q <= border ? COL_BG : type_colour(addr[SCAN_W+1:SCAN_W]);
    end

endmodule
`endif

// File: rtl/item_drawer.sv
// Per-frame walk of the item RAM: erase stale 16x16 footprints and plot current ones.
// Build option ITEM_SPRITE_ROM_EN: draw colours from item_sprite_rom (one extra pixel-pipe stage).
module item_drawer
    import item_pkg::*;
#(
    parameter int unsigned FRAME_CLOCK = 833_334,
    parameter int unsigned READ_LAT    = 2
)
(
    input  logic               clock,
    input  logic               resetn,
    input  logic               enable,
    input  logic [IDX_W-1:0]   quantity,
    input  logic [31:0]        data,
    output logic               draw_stone_flag,
    output logic [IDX_W-1:0]   draw_index,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic [COL_W-1:0]   colour,
    output logic               plot,
    output logic               frame_done
);

    localparam int unsigned CNT_W = $clog2(FRAME_CLOCK);
    localparam int unsigned LAT_W = 4;
    localparam logic [CNT_W-1:0]  FRAME_LAST = CNT_W'(FRAME_CLOCK - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST  = SCAN_W'(SPRITE_SIZE * SPRITE_SIZE - 1);
    localparam logic [LAT_W-1:0]  LAT_LAST   = LAT_W'(READ_LAT - 1);

    state_t              state;
    logic [CNT_W-1:0]    frame_cnt;
    logic [IDX_W-1:0]    index;
    logic [LAT_W-1:0]    wait_cnt;
    logic [SCAN_W-1:0]   scan;
    logic [COORD_W-1:0]  rec_x;
    logic [COORD_W-1:0]  rec_y;
    logic [1:0]          rec_type;
    logic                rec_vis;
    logic                sh_we;
    logic [SHADOW_W-1:0] sh_wdata;
    logic [SHADOW_W-1:0] sh_rdata;
    shadow_t             sh;
    logic [COORD_W-1:0]  s1_x;
    logic [COORD_W-1:0]  s1_y;
    logic [COL_W-1:0]    s1_col;
    logic                s1_plot;
`ifdef ITEM_SPRITE_ROM_EN
    logic                s1_draw;
`endif

    logic                   erase_need;
    logic [COORD_W-1:0]     base_x;
    logic [COORD_W-1:0]     base_y;
    logic [COORD_W:0]       sum_x;
    logic [COORD_W:0]       sum_y;
    logic                   in_bounds;
    logic                   unused_data;

    assign sh = shadow_t'(sh_rdata);

    item_shadow u_shadow (
        .clock   (clock),
        .resetn  (resetn),
        .rd_addr (index),
        .rd_data (sh_rdata),
        .wr_en   (sh_we),
        .wr_addr (index),
        .wr_data (sh_wdata)
    );

    assign erase_need = sh.valid && (!rec_vis || (sh.x != rec_x) || (sh.y != rec_y));

    // Erase scans the remembered footprint, draw scans the freshly read one.
    assign base_x    = (state == S_ERASE) ? sh.x : rec_x;
    assign base_y    = (state == S_ERASE) ? sh.y : rec_y;
    assign sum_x     = (COORD_W+1)'(base_x) + (COORD_W+1)'(scan[SPRITE_BITS-1:0]);
    assign sum_y     = (COORD_W+1)'(base_y) + (COORD_W+1)'(scan[SCAN_W-1:SPRITE_BITS]);
    assign in_bounds = (sum_x < (COORD_W+1)'(SCREEN_W)) && (sum_y < (COORD_W+1)'(SCREEN_H));

    assign unused_data = ^{data[31:X_MSB+1], data[X_LSB-1:Y_MSB+1], data[Y_LSB-1:TYPE_MSB+1], data[MOVING]};

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state           <= S_IDLE;
            frame_cnt       <= '0;
            index           <= '0;
            wait_cnt        <= '0;
            scan            <= '0;
            rec_x           <= '0;
            rec_y           <= '0;
            rec_type        <= '0;
            rec_vis         <= 1'b0;
            sh_we           <= 1'b0;
            sh_wdata        <= '0;
            s1_x            <= '0;
            s1_y            <= '0;
            s1_col          <= '0;
            s1_plot         <= 1'b0;
`ifdef ITEM_SPRITE_ROM_EN
            s1_draw         <= 1'b0;
`endif
            draw_stone_flag <= 1'b0;
            draw_index      <= '0;
            frame_done      <= 1'b0;
        end else begin
            frame_cnt  <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + CNT_W'(1);
            frame_done <= 1'b0;
            sh_we      <= 1'b0;
            s1_plot    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (frame_cnt == FRAME_LAST && enable) state <= S_ADDR;
                end
                S_ADDR: begin
                    draw_stone_flag <= 1'b1;
                    draw_index      <= index;
                    wait_cnt        <= '0;
                    state           <= (index >= quantity) ? S_DONE : S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt == LAT_LAST) begin
                        rec_x    <= data[X_MSB:X_LSB];
                        rec_y    <= data[Y_MSB:Y_LSB];
                        rec_type <= data[TYPE_MSB:TYPE_LSB];
                        rec_vis  <= data[VISIBLE];
                        state    <= S_DECODE;
                    end else begin
                        wait_cnt <= wait_cnt + LAT_W'(1);
                    end
                end
                S_DECODE: begin
                    scan <= '0;
                    if (erase_need)   state <= S_ERASE;
                    else if (rec_vis) state <= S_DRAW;
                    else              state <= S_NEXT;
                end
                S_ERASE: begin
                    s1_x    <= sum_x[COORD_W-1:0];
                    s1_y    <= sum_y[COORD_W-1:0];
                    s1_plot <= in_bounds;
                    s1_col  <= COL_BG;
`ifdef ITEM_SPRITE_ROM_EN
                    s1_draw <= 1'b0;
`endif
                    scan    <= scan + SCAN_W'(1);
                    if (scan == SCAN_LAST) begin
                        if (rec_vis) begin
                            state <= S_DRAW;
                        end else begin
                            sh_we    <= 1'b1;
                            sh_wdata <= '0;
                            state    <= S_NEXT;
                        end
                    end
                end
                S_DRAW: begin
                    s1_x    <= sum_x[COORD_W-1:0];
                    s1_y    <= sum_y[COORD_W-1:0];
                    s1_plot <= in_bounds;
                    s1_col  <= type_colour(rec_type);
`ifdef ITEM_SPRITE_ROM_EN
                    s1_draw <= 1'b1;
`endif
                    scan    <= scan + SCAN_W'(1);
                    if (scan == SCAN_LAST) begin
                        sh_we    <= 1'b1;
                        sh_wdata <= {1'b1, rec_x, rec_y};
                        state    <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    index <= index + IDX_W'(1);
                    state <= S_ADDR;
                end
                S_DONE: begin
                    draw_stone_flag <= 1'b0;
                    frame_done      <= 1'b1;
                    index           <= '0;
                    state           <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef ITEM_SPRITE_ROM_EN
    logic [COL_W-1:0] rom_q;

    item_sprite_rom u_rom (
        .clock  (clock),
        .resetn (resetn),
        .addr   ({rec_type, scan}),
        .q      (rom_q)
    );

    // Second pixel stage lines coordinates up with the ROM's registered colour.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            x      <= '0;
            y      <= '0;
            colour <= '0;
            plot   <= 1'b0;
        end else begin
            x      <= s1_x;
            y      <= s1_y;
            colour <= s1_draw ? rom_q : s1_col;
            plot   <= s1_plot && (!s1_draw || (rom_q != COL_BG));
        end
    end
`else
    assign x      = s1_x;
    assign y      = s1_y;
    assign colour = s1_col;
    assign plot   = s1_plot;
`endif

endmodule

// File: tb/tb_item_drawer.sv
// Scoreboard bench for item_drawer: expected pixels are queued per frame, a monitor pops and compares.
module tb_item_drawer;

    localparam int unsigned FRAME_CLOCK = 1200;
    localparam int unsigned READ_LAT    = 2;
    localparam logic [8:0] C_BG   = 9'h000;
    localparam logic [8:0] C_STN  = 9'h16D;
    localparam logic [8:0] C_GLD  = 9'h1F8;
    localparam logic [8:0] C_DIA  = 9'h03F;

    logic        clock  = 1'b0;
    logic        resetn = 1'b0;
    logic        enable = 1'b0;
    logic [3:0]  quantity = '0;
    logic [31:0] data;
    logic        draw_stone_flag;
    logic [3:0]  draw_index;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [8:0]  colour;
    logic        plot;
    logic        frame_done;

    always #5 clock = ~clock;

    item_drawer #(.FRAME_CLOCK(FRAME_CLOCK), .READ_LAT(READ_LAT)) dut (
        .clock           (clock),
        .resetn          (resetn),
        .enable          (enable),
        .quantity        (quantity),
        .data            (data),
        .draw_stone_flag (draw_stone_flag),
        .draw_index      (draw_index),
        .x               (x),
        .y               (y),
        .colour          (colour),
        .plot            (plot),
        .frame_done      (frame_done)
    );

    // RAM model: the word is valid only in the single cycle before the READ_LAT-th edge after an address change.
    logic [31:0] mem [16];
    logic [3:0]  last_idx  = '0;
    logic        last_flag = 1'b0;
    int          since     = 15;
    logic        changed;

    assign changed = (draw_index != last_idx) || (draw_stone_flag && !last_flag);
    assign data    = (since == int'(READ_LAT) - 1) ? mem[draw_index] : 32'hDEAD_BEEF;

    always @(posedge clock) begin
        last_idx  <= draw_index;
        last_flag <= draw_stone_flag;
        since     <= changed ? 1 : ((since < 15) ? since + 1 : since);
    end

    int checks   = 0;
    int errors   = 0;
    int plot_cnt = 0;
    int fd_cnt   = 0;
    int flag_cyc = 0;
    logic [28:0] exp_q [$];

    always @(negedge clock) begin
        if (resetn) begin
            if (draw_stone_flag) flag_cyc++;
            if (frame_done) fd_cnt++;
            if (plot) begin
                logic [28:0] e;
                plot_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pixel actual x=%0d y=%0d c=%h required none", x, y, colour);
                end else begin
                    e = exp_q.pop_front();
                    if ({x, y, colour} != e) begin
                        errors++;
                        $display("FAIL pixel actual x=%0d y=%0d c=%h required x=%0d y=%0d c=%h",
                                 x, y, colour, e[28:19], e[18:9], e[8:0]);
                    end
                end
            end
        end
    end

    function automatic logic [31:0] mk_rec(input int px, input int py, input logic [1:0] t,
                                           input logic vis, input logic mov);
        return {3'b101, 10'(px), 2'b11, 10'(py), 3'b110, t, vis, mov};
    endfunction

    task automatic push_scan(input int bx, input int by, input logic [8:0] c);
        for (int r = 0; r < 16; r++)
            for (int k = 0; k < 16; k++)
                if (bx + k < 320 && by + r < 240)
                    exp_q.push_back({10'(bx + k), 10'(by + r), c});
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic run_frame(input string name, input int exp_flag);
        int n;
        fd_cnt   = 0;
        flag_cyc = 0;
        n = 0;
        while (fd_cnt == 0 && n < 3 * int'(FRAME_CLOCK)) begin
            @(posedge clock);
            n++;
        end
        chk({name, "_done_seen"}, (fd_cnt != 0) ? 1 : 0, 1);
        repeat (4) @(posedge clock);
        chk({name, "_done_pulses"}, fd_cnt, 1);
        chk({name, "_pending"}, exp_q.size(), 0);
        chk({name, "_flag_low"}, int'(draw_stone_flag), 0);
        if (exp_flag >= 0) chk({name, "_flag_cycles"}, flag_cyc, exp_flag);
    endtask

    initial begin
        int p0;
        int n;
        for (int i = 0; i < 16; i++) mem[i] = '0;

        repeat (3) @(posedge clock);
        #1;
        chk("rst_plot", int'(plot), 0);
        chk("rst_flag", int'(draw_stone_flag), 0);
        chk("rst_done", int'(frame_done), 0);
        chk("rst_xyc", int'({x, y, colour, draw_index}), 0);

        @(negedge clock);
        resetn   = 1'b1;
        enable   = 1'b1;
        quantity = 4'd1;
        mem[0]   = mk_rec(40, 60, 2'b01, 1'b1, 1'b1);
        push_scan(40, 60, C_GLD);
        run_frame("gold_first", 262);

        mem[0] = mk_rec(40, 52, 2'b01, 1'b1, 1'b0);
        push_scan(40, 60, C_BG);
        push_scan(40, 52, C_GLD);
        run_frame("moved", 518);

        mem[0] = mk_rec(40, 52, 2'b01, 1'b0, 1'b0);
        push_scan(40, 52, C_BG);
        run_frame("hidden", 262);

        p0 = plot_cnt;
        run_frame("hidden_again", 6);
        chk("hidden_again_plots", plot_cnt - p0, 0);

        mem[0] = mk_rec(310, 230, 2'b11, 1'b1, 1'b0);
        p0 = plot_cnt;
        push_scan(310, 230, C_DIA);
        run_frame("corner", 262);
        chk("corner_plots", plot_cnt - p0, 100);

        quantity = 4'd0;
        p0 = plot_cnt;
        run_frame("empty", 1);
        chk("empty_plots", plot_cnt - p0, 0);

        // Reset while the stone is halfway drawn: erase of the corner item (100) plus 50 draw pixels.
        quantity = 4'd1;
        mem[0]   = mk_rec(100, 100, 2'b00, 1'b1, 1'b0);
        push_scan(310, 230, C_BG);
        push_scan(100, 100, C_STN);
        p0 = plot_cnt;
        n  = 0;
        while (plot_cnt < p0 + 150 && n < 3 * int'(FRAME_CLOCK)) begin
            @(posedge clock);
            n++;
        end
        chk("mid_draw_reached", (plot_cnt >= p0 + 150) ? 1 : 0, 1);
        #2 resetn = 1'b0;
        #1;
        chk("mid_rst_plot", int'(plot), 0);
        chk("mid_rst_flag", int'(draw_stone_flag), 0);
        exp_q.delete();
        repeat (3) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        push_scan(100, 100, C_STN);
        run_frame("after_reset", 262);

        quantity = 4'd2;
        mem[1]   = mk_rec(0, 0, 2'b01, 1'b1, 1'b1);
        push_scan(100, 100, C_STN);
        push_scan(0, 0, C_GLD);
        n = 0;
        while (!draw_stone_flag && n < 3 * int'(FRAME_CLOCK)) begin
            @(posedge clock);
            n++;
        end
        chk("two_items_started", int'(draw_stone_flag), 1);
        enable = 1'b0;
        run_frame("enable_drop", -1);

        p0     = plot_cnt;
        fd_cnt = 0;
        repeat (2 * FRAME_CLOCK + 10) @(posedge clock);
        chk("disabled_frames", fd_cnt, 0);
        chk("disabled_plots", plot_cnt - p0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
